// File: rtl/div_pkg.sv
// Shared divider definitions: FSM state encoding and default width.
// Used by the ex stage and the divider files.
package div_pkg;

   localparam int DIV_WIDTH = 32;

   localparam logic [1:0] DIV_IDLE   = 2'b00;
   localparam logic [1:0] DIV_BYZERO = 2'b01;
   localparam logic [1:0] DIV_ON     = 2'b10;
   localparam logic [1:0] DIV_END    = 2'b11;

endpackage

// File: rtl/div_unit_p_if.sv
// Start/ready bundle between the ex stage (master) and the divider (slave).
// The result is {remainder, quotient}.
interface div_unit_p_if
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) ();

   logic               signed_div_i;
   logic [WIDTH-1:0]   opdata1_i;
   logic [WIDTH-1:0]   opdata2_i;
   logic               start_i;
   logic               annul_i;
   logic [2*WIDTH-1:0] result_o;
   logic               ready_o;
   logic               busy_o;
   logic               div_by_zero_o;

   modport master (
      output signed_div_i,
      output opdata1_i,
      output opdata2_i,
      output start_i,
      output annul_i,
      input  result_o,
      input  ready_o,
      input  busy_o,
      input  div_by_zero_o
   );

   modport slave (
      input  signed_div_i,
      input  opdata1_i,
      input  opdata2_i,
      input  start_i,
      input  annul_i,
      output result_o,
      output ready_o,
      output busy_o,
      output div_by_zero_o
   );

endinterface

// File: rtl/div_step.sv
// One restoring radix-2 step on a (2W+1)-bit partial remainder.
// Low W bits collect quotient bits; high part is the running remainder.
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [2*WIDTH:0] rem_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [2*WIDTH:0] rem_o,
   output logic             q_o
);

   logic [WIDTH:0]   hi;
   logic [WIDTH-2:0] lo;
   logic [WIDTH+1:0] diff;
   logic             unused_msb;

   // The top bit is always shifted out; remainder < divisor keeps it zero.
   assign unused_msb = rem_i[2*WIDTH];

   assign hi   = rem_i[2*WIDTH-1:WIDTH-1];
   assign lo   = rem_i[WIDTH-2:0];
   assign diff = {1'b0, hi} - {2'b00, divisor_i};
   assign q_o  = ~diff[WIDTH+1];

   // Keep the difference only when the trial subtraction did not borrow.
   always_comb begin
      rem_o = {hi, lo, 1'b0};
      if (q_o) begin
         rem_o = {diff[WIDTH:0], lo, 1'b1};
      end
   end

endmodule

// File: rtl/div_unit_p.sv
// Multi-cycle signed/unsigned restoring divider, one quotient bit per cycle.
// Operands are captured at start; result holds until start drops.
module div_unit_p
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input logic         clk,
   input logic         rst,
   div_unit_p_if.slave bus
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [1:0]         state;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH:0]   rem;
   logic [WIDTH-1:0]   dvs;
   logic               sq;
   logic               sr;

   logic [2*WIDTH:0]   rem_nx;
   logic               q_bit;
   logic               s1;
   logic               s2;
   logic [WIDTH-1:0]   op1_mag;
   logic [WIDTH-1:0]   op2_mag;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rmd;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rmd_fix;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i     (rem),
      .divisor_i (dvs),
      .rem_o     (rem_nx),
      .q_o       (q_bit)
   );

   assign s1 = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
   assign s2 = bus.signed_div_i & bus.opdata2_i[WIDTH-1];

   // Signed MIN maps to 2^(W-1), which still fits as an unsigned magnitude.
   assign op1_mag = s1 ? -bus.opdata1_i : bus.opdata1_i;
   assign op2_mag = s2 ? -bus.opdata2_i : bus.opdata2_i;

   assign quo     = {rem_nx[WIDTH-1:1], q_bit};
   assign rmd     = rem_nx[2*WIDTH-1:WIDTH];
   assign quo_fix = sq ? -quo : quo;
   assign rmd_fix = sr ? -rmd : rmd;

   // FSM, iteration counter and registered outputs; annul wins everywhere.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= DIV_IDLE;
         cnt               <= '0;
         rem               <= '0;
         dvs               <= '0;
         sq                <= 1'b0;
         sr                <= 1'b0;
         bus.result_o      <= '0;
         bus.ready_o       <= 1'b0;
         bus.busy_o        <= 1'b0;
         bus.div_by_zero_o <= 1'b0;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (bus.start_i && !bus.annul_i) begin
                  dvs        <= op2_mag;
                  sq         <= s1 ^ s2;
                  sr         <= s1;
                  cnt        <= '0;
                  bus.busy_o <= 1'b1;
                  if (bus.opdata2_i == '0) begin
                     // Zero path reports the dividend as given, not its magnitude.
                     rem   <= {{(WIDTH+1){1'b0}}, bus.opdata1_i};
                     state <= DIV_BYZERO;
                  end else begin
                     rem   <= {{(WIDTH+1){1'b0}}, op1_mag};
                     state <= DIV_ON;
                  end
               end
            end
            DIV_BYZERO: begin
               bus.busy_o <= 1'b0;
               if (bus.annul_i) begin
                  state <= DIV_IDLE;
               end else begin
                  bus.result_o      <= {rem[WIDTH-1:0], {WIDTH{1'b1}}};
                  bus.div_by_zero_o <= 1'b1;
                  bus.ready_o       <= 1'b1;
                  state             <= DIV_END;
               end
            end
            DIV_ON: begin
               if (bus.annul_i) begin
                  bus.busy_o <= 1'b0;
                  state      <= DIV_IDLE;
               end else begin
                  rem <= rem_nx;
                  cnt <= cnt + CW'(1);
                  if (cnt == LAST) begin
                     bus.result_o <= {rmd_fix, quo_fix};
                     bus.ready_o  <= 1'b1;
                     bus.busy_o   <= 1'b0;
                     state        <= DIV_END;
                  end
               end
            end
            DIV_END: begin
               if (!bus.start_i || bus.annul_i) begin
                  bus.ready_o       <= 1'b0;
                  bus.div_by_zero_o <= 1'b0;
                  state             <= DIV_IDLE;
               end
            end
            default: begin
               state <= DIV_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit_p.sv
// Randomised bench for div_unit_p at WIDTH=32 and WIDTH=8.
// Expected results come from plain integer division on 64-bit values.
module tb_div_unit_p;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   div_unit_p_if #(.WIDTH(32)) if32 ();
   div_unit_p_if #(.WIDTH(8))  if8 ();

   div_unit_p #(.WIDTH(32)) u32 (
      .clk (clk),
      .rst (rst),
      .bus (if32.slave)
   );

   div_unit_p #(.WIDTH(8)) u8 (
      .clk (clk),
      .rst (rst),
      .bus (if8.slave)
   );

   // Reference: {remainder, quotient} with truncating division.
   function automatic logic [63:0] ref_div(input int w, input bit sgn,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] m;
      longint sa, sb, q, r;
      m  = (64'd1 << w) - 64'd1;
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
      if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
      if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
      if (b == 32'd0) return ({32'b0, a} << w) | m;
      q = sa / sb;
      r = sa % sb;
      return ((64'(r) & m) << w) | (64'(q) & m);
   endfunction

   // Issue at the current negedge, wait for ready at following negedges.
   task automatic do_op32(input bit sgn, input logic [31:0] a,
                          input logic [31:0] b, input bit scramble,
                          output int lat, output int bsy,
                          output logic [63:0] res, output logic dbz);
      if32.signed_div_i = sgn;
      if32.opdata1_i    = a;
      if32.opdata2_i    = b;
      if32.annul_i      = 1'b0;
      if32.start_i      = 1'b1;
      lat = 0;
      bsy = 0;
      do begin
         @(negedge clk);
         lat++;
         if (if32.busy_o) bsy++;
         if (scramble) begin
            if32.opdata1_i    = $urandom;
            if32.opdata2_i    = $urandom;
            if32.signed_div_i = ~sgn;
         end
      end while (!if32.ready_o && lat < 80);
      res = if32.result_o;
      dbz = if32.div_by_zero_o;
   endtask

   task automatic do_op8(input bit sgn, input logic [7:0] a,
                         input logic [7:0] b,
                         output int lat, output int bsy,
                         output logic [15:0] res, output logic dbz);
      if8.signed_div_i = sgn;
      if8.opdata1_i    = a;
      if8.opdata2_i    = b;
      if8.annul_i      = 1'b0;
      if8.start_i      = 1'b1;
      lat = 0;
      bsy = 0;
      do begin
         @(negedge clk);
         lat++;
         if (if8.busy_o) bsy++;
      end while (!if8.ready_o && lat < 40);
      res = if8.result_o;
      dbz = if8.div_by_zero_o;
   endtask

   task automatic release32();
      if32.start_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic release8();
      if8.start_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      if32.signed_div_i = 1'b0;
      if32.opdata1_i    = '0;
      if32.opdata2_i    = '0;
      if32.start_i      = 1'b0;
      if32.annul_i      = 1'b0;
      if8.signed_div_i  = 1'b0;
      if8.opdata1_i     = '0;
      if8.opdata2_i     = '0;
      if8.start_i       = 1'b0;
      if8.annul_i       = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (if32.result_o !== 64'd0) begin
         errors++;
         $display("FAIL reset_result: got %h want 0", if32.result_o);
      end
      checks++;
      if ({if32.ready_o, if32.busy_o, if32.div_by_zero_o} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags: got %b want 000",
                  {if32.ready_o, if32.busy_o, if32.div_by_zero_o});
      end
      checks++;
      if ({if8.result_o, if8.ready_o, if8.busy_o, if8.div_by_zero_o} !== 19'd0) begin
         errors++;
         $display("FAIL reset_w8: got %h want 0",
                  {if8.result_o, if8.ready_o, if8.busy_o, if8.div_by_zero_o});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_unsigned();
      int lat, bsy;
      logic [63:0] res;
      logic dbz;
      do_op32(1'b0, 32'd100, 32'd7, 1'b0, lat, bsy, res, dbz);
      checks++;
      if (lat !== 33) begin
         errors++;
         $display("FAIL u_latency: got %0d want 33", lat);
      end
      checks++;
      if (res !== {32'd2, 32'd14}) begin
         errors++;
         $display("FAIL u_100_7: got %h want %h", res, {32'd2, 32'd14});
      end
      checks++;
      if (dbz !== 1'b0 || bsy !== 32) begin
         errors++;
         $display("FAIL u_flags: got dbz=%b busy=%0d want 0/32", dbz, bsy);
      end
      release32();
      checks++;
      if (if32.ready_o !== 1'b0) begin
         errors++;
         $display("FAIL u_release: ready %b want 0", if32.ready_o);
      end
   endtask

   task automatic test_signed();
      int lat, bsy;
      logic [63:0] res;
      logic dbz;
      do_op32(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, bsy, res, dbz);
      checks++;
      if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
         errors++;
         $display("FAIL s_m7_2: got %h want ffffffff_fffffffd", res);
      end
      release32();
      do_op32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, bsy, res, dbz);
      checks++;
      if (res !== {32'd0, 32'h8000_0000} || dbz !== 1'b0) begin
         errors++;
         $display("FAIL s_min_m1: got %h dbz=%b want 0_80000000/0", res, dbz);
      end
      release32();
   endtask

   task automatic test_byzero();
      int lat, bsy;
      logic [15:0] r8;
      logic [63:0] r32;
      logic dbz;
      do_op8(1'b0, 8'h5A, 8'h00, lat, bsy, r8, dbz);
      checks++;
      if (lat !== 2 || bsy !== 1) begin
         errors++;
         $display("FAIL z_timing: got lat=%0d busy=%0d want 2/1", lat, bsy);
      end
      checks++;
      if (r8 !== 16'h5AFF || dbz !== 1'b1) begin
         errors++;
         $display("FAIL z_result: got %h dbz=%b want 5aff/1", r8, dbz);
      end
      release8();
      checks++;
      if (if8.div_by_zero_o !== 1'b0 || if8.ready_o !== 1'b0) begin
         errors++;
         $display("FAIL z_clear: got dbz=%b rdy=%b want 0/0",
                  if8.div_by_zero_o, if8.ready_o);
      end
      do_op32(1'b1, 32'hFFFF_FF00, 32'd0, 1'b0, lat, bsy, r32, dbz);
      checks++;
      if (r32 !== {32'hFFFF_FF00, 32'hFFFF_FFFF} || dbz !== 1'b1) begin
         errors++;
         $display("FAIL z_signed: got %h dbz=%b want ffffff00_ffffffff/1", r32, dbz);
      end
      release32();
   endtask

   task automatic test_annul();
      int lat, bsy;
      bit seen;
      logic [63:0] res;
      logic dbz;
      if32.signed_div_i = 1'b0;
      if32.opdata1_i    = 32'hDEAD_BEEF;
      if32.opdata2_i    = 32'h1234;
      if32.start_i      = 1'b1;
      seen = 1'b0;
      repeat (11) begin
         @(negedge clk);
         if (if32.ready_o) seen = 1'b1;
      end
      if32.annul_i = 1'b1;
      @(negedge clk);
      checks++;
      if (if32.busy_o !== 1'b0 || if32.ready_o !== 1'b0 || seen) begin
         errors++;
         $display("FAIL a_abort: got busy=%b rdy=%b seen=%b want 0/0/0",
                  if32.busy_o, if32.ready_o, seen);
      end
      do_op32(1'b0, 32'd9, 32'd3, 1'b0, lat, bsy, res, dbz);
      checks++;
      if (res !== {32'd0, 32'd3} || lat !== 33) begin
         errors++;
         $display("FAIL a_restart: got %h lat=%0d want 0_3/33", res, lat);
      end
      release32();
      // Annul arriving with the final step must leave the result untouched.
      if32.opdata1_i = 32'd1000;
      if32.opdata2_i = 32'd10;
      if32.start_i   = 1'b1;
      repeat (32) @(negedge clk);
      if32.annul_i = 1'b1;
      @(negedge clk);
      checks++;
      if (if32.ready_o !== 1'b0 || if32.result_o !== {32'd0, 32'd3}) begin
         errors++;
         $display("FAIL a_last: got rdy=%b res=%h want 0/0_3",
                  if32.ready_o, if32.result_o);
      end
      if32.annul_i = 1'b0;
      if32.start_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_hold();
      int lat, bsy;
      logic [63:0] res, exp;
      logic dbz;
      logic [31:0] a, b;
      exp = ref_div(32, 1'b0, 32'd1000003, 32'd17);
      do_op32(1'b0, 32'd1000003, 32'd17, 1'b1, lat, bsy, res, dbz);
      checks++;
      if (res !== exp || lat !== 33) begin
         errors++;
         $display("FAIL h_result: got %h lat=%0d want %h/33", res, lat, exp);
      end
      for (int i = 0; i < 5; i++) begin
         if32.opdata1_i = $urandom;
         @(negedge clk);
         checks++;
         if (if32.ready_o !== 1'b1 || if32.result_o !== exp) begin
            errors++;
            $display("FAIL h_stable%0d: got rdy=%b res=%h want 1/%h",
                     i, if32.ready_o, if32.result_o, exp);
         end
      end
      release32();
      checks++;
      if (if32.ready_o !== 1'b0 || if32.busy_o !== 1'b0) begin
         errors++;
         $display("FAIL h_idle: got rdy=%b busy=%b want 0/0",
                  if32.ready_o, if32.busy_o);
      end
      a = $urandom;
      b = $urandom_range(1, 5000);
      exp = ref_div(32, 1'b1, a, b);
      do_op32(1'b1, a, b, 1'b0, lat, bsy, res, dbz);
      checks++;
      if (res !== exp || lat !== 33) begin
         errors++;
         $display("FAIL h_next: got %h lat=%0d want %h/33", res, lat, exp);
      end
      release32();
   endtask

   task automatic test_reset_mid();
      int lat, bsy;
      logic [63:0] res;
      logic dbz;
      if32.opdata1_i = 32'd77777;
      if32.opdata2_i = 32'd3;
      if32.start_i   = 1'b1;
      repeat (8) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({if32.result_o, if32.ready_o, if32.busy_o, if32.div_by_zero_o} !== 67'd0) begin
         errors++;
         $display("FAIL r_async: got res=%h rdy=%b busy=%b want all 0",
                  if32.result_o, if32.ready_o, if32.busy_o);
      end
      @(negedge clk);
      rst = 1'b0;
      do_op32(1'b0, 32'd123456, 32'd1000, 1'b0, lat, bsy, res, dbz);
      checks++;
      if (res !== {32'd456, 32'd123} || lat !== 33) begin
         errors++;
         $display("FAIL r_after: got %h lat=%0d want 1c8_7b/33", res, lat);
      end
      release32();
   endtask

   task automatic test_random();
      int lat, bsy, sel;
      bit sgn;
      logic [31:0] a, b;
      logic [63:0] res, exp;
      logic [15:0] r8, e8;
      logic dbz;
      for (int i = 0; i < 40; i++) begin
         sgn = 1'($urandom_range(0, 1));
         a   = $urandom;
         b   = $urandom;
         sel = $urandom_range(0, 5);
         case (sel)
            0: b = 32'd0;
            1: b = $urandom_range(1, 15);
            2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            3: begin
               a = $urandom_range(0, 99);
               b = $urandom_range(100, 1000);
            end
            default: ;
         endcase
         exp = ref_div(32, sgn, a, b);
         do_op32(sgn, a, b, 1'b0, lat, bsy, res, dbz);
         checks++;
         if (res !== exp || lat !== ((b == 0) ? 2 : 33) || dbz !== (b == 0)) begin
            errors++;
            $display("FAIL rnd32_%0d: s=%b %h/%h got %h lat=%0d z=%b want %h",
                     i, sgn, a, b, res, lat, dbz, exp);
         end
         release32();
      end
      for (int i = 0; i < 30; i++) begin
         sgn = 1'($urandom_range(0, 1));
         a   = 32'($urandom_range(0, 255));
         b   = 32'($urandom_range(0, 255));
         if (i % 7 == 0) b = 32'd0;
         if (i % 7 == 3) begin a = 32'h80; b = 32'hFF; end
         e8 = 16'(ref_div(8, sgn, a, b));
         do_op8(sgn, a[7:0], b[7:0], lat, bsy, r8, dbz);
         checks++;
         if (r8 !== e8 || lat !== ((b == 0) ? 2 : 9) || dbz !== (b == 0)) begin
            errors++;
            $display("FAIL rnd8_%0d: s=%b %h/%h got %h lat=%0d z=%b want %h",
                     i, sgn, a[7:0], b[7:0], r8, lat, dbz, e8);
         end
         release8();
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_byzero();
      test_annul();
      test_hold();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
